// File: rtl/mpu_eth_pkg.sv
// Shared types and constants for the MPU Ethernet receive path.
package mpu_eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR1,
        HDR2,
        HDR3,
        PAYLOAD,
        DROP
    } rx_state_t;

    // Word offsets within a shift16-padded Ethernet header
    localparam int HDR_DST_HI_WORD = 0;
    localparam int HDR_DST_LO_WORD = 1;
    localparam int HDR_SRC_WORD    = 2;
    localparam int HDR_TYPE_WORD   = 3;
    localparam int PAYLOAD_WORD    = 4;

    localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] DEF_ETHERTYPE = 16'h88B5;

endpackage

// File: rtl/mpu_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module mpu_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/mpu_rx_frame_parser.sv
// Filters MAC receive frames by destination/EtherType, strips the padded
// header and forwards the word-aligned payload through a one-deep output register.
module mpu_rx_frame_parser #(
    parameter int          STAT_W        = 16,
    parameter logic [15:0] DEF_ETHERTYPE = mpu_eth_pkg::DEF_ETHERTYPE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       rx_data,
    input  logic              rx_valid,
    input  logic              rx_sop,
    input  logic              rx_eop,
    input  logic [1:0]        rx_empty,
    input  logic [5:0]        rx_err,
    output logic              rx_ready,
    input  logic [47:0]       cfg_mac_addr,
    input  logic [15:0]       cfg_ethertype,
    input  logic              cfg_promisc,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic [1:0]        out_empty,
    output logic              out_err,
    output logic [STAT_W-1:0] stat_accepted,
    output logic [STAT_W-1:0] stat_filtered,
    output logic [STAT_W-1:0] stat_errored
);

    import mpu_eth_pkg::*;

    rx_state_t   state;
    logic [15:0] dst_hi;
    logic [31:0] dst_lo;
    logic [15:0] type_shadow;
    logic        first_pending;
    logic        out_free, xfer, sop_abort, match;
    logic        inc_acc, inc_filt, inc_err;

    always_comb begin
        out_free = ~out_valid | out_ready;
        rx_ready = 1'b1;
        // A sop inside a payload is held off until the abort beat is out
        if (state == PAYLOAD)
            rx_ready = out_free & ~(rx_valid & rx_sop);
        xfer      = rx_valid & rx_ready;
        sop_abort = (state == PAYLOAD) & rx_valid & rx_sop & out_free;
        match     = (({dst_hi, dst_lo} == cfg_mac_addr) |
                     ({dst_hi, dst_lo} == BROADCAST_MAC) | cfg_promisc) &
                    (rx_data[15:0] == type_shadow);

        inc_acc  = 1'b0;
        inc_filt = 1'b0;
        inc_err  = 1'b0;
        unique case (state)
            IDLE:       inc_filt = xfer & rx_sop & rx_eop;
            HDR1, HDR2: inc_filt = xfer & (rx_sop | rx_eop);
            HDR3:       inc_filt = xfer & (rx_sop | rx_eop | ~match);
            PAYLOAD: begin
                inc_acc = xfer & rx_eop & ~(|rx_err);
                inc_err = sop_abort | (xfer & rx_eop & (|rx_err));
            end
            DROP:       inc_filt = xfer & rx_sop;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            dst_hi        <= '0;
            dst_lo        <= '0;
            type_shadow   <= DEF_ETHERTYPE;
            first_pending <= 1'b0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            out_sop       <= 1'b0;
            out_eop       <= 1'b0;
            out_empty     <= '0;
            out_err       <= 1'b0;
        end else begin
            type_shadow <= cfg_ethertype;
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (xfer && rx_sop && !rx_eop) begin
                        dst_hi <= rx_data[15:0];
                        state  <= HDR1;
                    end
                end
                HDR1, HDR2, HDR3, DROP: begin
                    if (xfer) begin
                        if (rx_sop && !rx_eop) begin
                            dst_hi <= rx_data[15:0];
                            state  <= HDR1;
                        end else if (rx_eop) begin
                            state <= IDLE;
                        end else if (state == HDR1) begin
                            dst_lo <= rx_data;
                            state  <= HDR2;
                        end else if (state == HDR2) begin
                            state <= HDR3;
                        end else if (state == HDR3) begin
                            state         <= match ? PAYLOAD : DROP;
                            first_pending <= 1'b1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (sop_abort) begin
                        out_valid <= 1'b1;
                        out_data  <= '0;
                        out_sop   <= 1'b0;
                        out_eop   <= 1'b1;
                        out_empty <= '0;
                        out_err   <= 1'b1;
                        state     <= IDLE;
                    end else if (xfer) begin
                        out_valid     <= 1'b1;
                        out_data      <= rx_data;
                        out_sop       <= first_pending;
                        out_eop       <= rx_eop;
                        out_empty     <= rx_eop ? rx_empty : 2'b00;
                        out_err       <= rx_eop & (|rx_err);
                        first_pending <= 1'b0;
                        if (rx_eop)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mpu_sat_counter #(.W(STAT_W)) u_cnt_acc (
        .clk(clk), .reset_n(reset_n), .inc(inc_acc),  .count(stat_accepted)
    );
    mpu_sat_counter #(.W(STAT_W)) u_cnt_filt (
        .clk(clk), .reset_n(reset_n), .inc(inc_filt), .count(stat_filtered)
    );
    mpu_sat_counter #(.W(STAT_W)) u_cnt_err (
        .clk(clk), .reset_n(reset_n), .inc(inc_err),  .count(stat_errored)
    );

endmodule

// File: tb/tb_mpu_rx_frame_parser.sv
// Randomized bench for mpu_rx_frame_parser: frame-level reference model,
// output scoreboard and stall-stability monitor.
module tb_mpu_rx_frame_parser;

    localparam int STAT_W = 4;
    localparam int SAT    = (1 << STAT_W) - 1;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
        logic        err;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [31:0]       rx_data = '0;
    logic              rx_valid = 1'b0, rx_sop = 1'b0, rx_eop = 1'b0;
    logic [1:0]        rx_empty = '0;
    logic [5:0]        rx_err = '0;
    logic              rx_ready;
    logic [47:0]       cfg_mac_addr = 48'h0200_0000_0011;
    logic [15:0]       cfg_ethertype = 16'h88B5;
    logic              cfg_promisc = 1'b0;
    logic [31:0]       out_data;
    logic              out_valid, out_sop, out_eop, out_err;
    logic              out_ready = 1'b1;
    logic [1:0]        out_empty;
    logic [STAT_W-1:0] stat_accepted, stat_filtered, stat_errored;

    int    checks = 0, failures = 0;
    int    cyc = 0;
    int    w4_cyc = -1, first_sop_cyc = -1;
    bit    rdy_mode = 1'b0;
    beat_t exp_q[$], act_q[$];
    int    exp_acc = 0, exp_filt = 0, exp_err = 0;

    mpu_rx_frame_parser #(.STAT_W(STAT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop),
        .rx_empty(rx_empty), .rx_err(rx_err), .rx_ready(rx_ready),
        .cfg_mac_addr(cfg_mac_addr), .cfg_ethertype(cfg_ethertype), .cfg_promisc(cfg_promisc),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty), .out_err(out_err),
        .stat_accepted(stat_accepted), .stat_filtered(stat_filtered), .stat_errored(stat_errored)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Collects transferred beats and checks hold-while-stalled behaviour
    initial begin
        beat_t cur, prev;
        bit    stall;
        stall = 1'b0;
        prev  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset_n) begin
                stall = 1'b0;
                continue;
            end
            cur = {out_data, out_sop, out_eop, out_empty, out_err};
            if (stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_beat", 64'(cur), 64'(prev));
            end
            if (out_valid && out_sop && first_sop_cyc < 0) first_sop_cyc = cyc;
            if (out_valid && out_ready) act_q.push_back(cur);
            stall = out_valid && !out_ready;
            prev  = cur;
        end
    end

    task automatic beat(input logic [31:0] d, input logic s, input logic e,
                        input logic [1:0] emp, input logic [5:0] er, output int acc_cyc);
        int guard;
        @(negedge clk);
        rx_valid = 1'b1; rx_data = d; rx_sop = s; rx_eop = e; rx_empty = emp; rx_err = er;
        #1;
        guard = 0;
        while (!rx_ready && guard < 2000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!rx_ready) chk("rx_ready_timeout", 64'(rx_ready), 64'd1);
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
    endtask

    // abort_at >= 0: stop after that many payload words with no eop (next sop aborts)
    task automatic send_frame(input logic [47:0] dst, input logic [15:0] eth, input int n,
                              input logic [5:0] err, input int abort_at, input bit gaps);
        logic [31:0] w[$];
        logic [31:0] r0, r1, pw;
        logic [47:0] src;
        logic [1:0]  emp;
        bit          m, last;
        int          nw, nsend, ac;
        r0 = $urandom; r1 = $urandom;
        src = {r0[15:0], r1};
        w.push_back({16'h0000, dst[47:32]});
        w.push_back(dst[31:0]);
        w.push_back(src[47:16]);
        w.push_back({src[15:0], eth});
        nw = (n + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            pw = '0;
            for (int b = 0; b < 4; b++)
                if (i * 4 + b < n) pw[31 - 8 * b -: 8] = 8'($urandom);
            w.push_back(pw);
        end
        emp = 2'((4 - n % 4) % 4);
        m = ((dst == cfg_mac_addr) || (dst == 48'hFFFF_FFFF_FFFF) || cfg_promisc) &&
            (eth == cfg_ethertype);
        nsend = (abort_at >= 0) ? 4 + abort_at : 4 + nw;
        for (int k = 0; k < nsend; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
            last = (abort_at < 0) && (k == nsend - 1);
            beat(w[k], k == 0, last, last ? emp : 2'($urandom), last ? err : 6'($urandom), ac);
            if (k == 4) w4_cyc = ac;
        end
        if (abort_at >= 0) begin
            for (int i = 0; i < abort_at; i++) exp_q.push_back({w[4 + i], i == 0, 1'b0, 2'b00, 1'b0});
            exp_q.push_back({32'h0, 1'b0, 1'b1, 2'b00, 1'b1});
            exp_err++;
        end else if (m) begin
            for (int i = 0; i < nw; i++)
                exp_q.push_back({w[4 + i], i == 0, i == nw - 1,
                                 (i == nw - 1) ? emp : 2'b00, (i == nw - 1) && (|err)});
            if (|err) exp_err++;
            else exp_acc++;
        end else begin
            exp_filt++;
        end
    endtask

    task automatic drain(input string tag);
        int g, nmin;
        g = 0;
        while (act_q.size() < exp_q.size() && g < 5000) begin
            @(negedge clk);
            g++;
        end
        repeat (4) @(negedge clk);
        #3;
        chk($sformatf("%s_nbeats", tag), 64'(act_q.size()), 64'(exp_q.size()));
        nmin = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++)
            chk($sformatf("%s_beat%0d", tag, i), 64'(act_q[i]), 64'(exp_q[i]));
        act_q.delete();
        exp_q.delete();
        chk($sformatf("%s_stat_acc", tag), 64'(stat_accepted), 64'(sat(exp_acc)));
        chk($sformatf("%s_stat_filt", tag), 64'(stat_filtered), 64'(sat(exp_filt)));
        chk($sformatf("%s_stat_err", tag), 64'(stat_errored), 64'(sat(exp_err)));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int ac;
        logic [47:0] dst;
        logic [15:0] eth;
        logic [31:0] r0, r1;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_flags", 64'({out_sop, out_eop, out_empty, out_err}), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_rx_ready", 64'(rx_ready), 64'd1);
        chk("rst_stats", 64'({stat_accepted, stat_filtered, stat_errored}), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // unicast 64 B, latency from word4
        first_sop_cyc = -1;
        send_frame(cfg_mac_addr, 16'h88B5, 64, 6'd0, -1, 1'b0);
        drain("unicast");
        chk("latency", 64'(first_sop_cyc), 64'(w4_cyc));

        // address filter and promiscuous mode
        send_frame(48'h0200_0000_0099, 16'h88B5, 20, 6'd0, -1, 1'b0);
        drain("filt_dst");
        cfg_promisc = 1'b1;
        send_frame(48'h0200_0000_0099, 16'h88B5, 20, 6'd0, -1, 1'b0);
        drain("promisc");
        cfg_promisc = 1'b0;

        // broadcast with wrong then right EtherType, 47-byte payload
        send_frame(48'hFFFF_FFFF_FFFF, 16'h0800, 47, 6'd0, -1, 1'b0);
        drain("bcast_type");
        send_frame(48'hFFFF_FFFF_FFFF, 16'h88B5, 47, 6'd0, -1, 1'b0);
        drain("bcast_47");

        // MAC error on eop
        send_frame(cfg_mac_addr, 16'h88B5, 32, 6'b000010, -1, 1'b0);
        drain("rx_err");

        // backpressure over 256 B with input gaps
        rdy_mode = 1'b1;
        send_frame(cfg_mac_addr, 16'h88B5, 256, 6'd0, -1, 1'b1);
        drain("stall256");

        // missing eop: abort beat then next frame
        rdy_mode = 1'b0;
        send_frame(cfg_mac_addr, 16'h88B5, 64, 6'd0, 6, 1'b0);
        send_frame(cfg_mac_addr, 16'h88B5, 24, 6'd0, -1, 1'b0);
        drain("abort");

        // runt: eop in the source-address word
        r0 = cfg_mac_addr[31:0];
        beat({16'h0, cfg_mac_addr[47:32]}, 1'b1, 1'b0, 2'b00, 6'd0, ac);
        beat(r0, 1'b0, 1'b0, 2'b00, 6'd0, ac);
        beat(32'h1234_5678, 1'b0, 1'b1, 2'b00, 6'd0, ac);
        exp_filt++;
        drain("runt");

        // reset pulsed mid-payload, trailing beats ignored
        send_frame(cfg_mac_addr, 16'h88B5, 40, 6'd0, 3, 1'b0);
        @(negedge clk);
        #3 reset_n = 1'b0;
        @(negedge clk);
        #3;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_stats", 64'({stat_accepted, stat_filtered, stat_errored}), 64'd0);
        reset_n = 1'b1;
        act_q.delete();
        exp_q.delete();
        exp_acc = 0; exp_filt = 0; exp_err = 0;
        beat(32'hDEAD_BEEF, 1'b0, 1'b0, 2'b00, 6'd0, ac);
        beat(32'h0200_0011, 1'b0, 1'b0, 2'b00, 6'd0, ac);
        beat(32'hCAFE_88B5, 1'b0, 1'b1, 2'b01, 6'd1, ac);
        drain("trailing");
        send_frame(cfg_mac_addr, 16'h88B5, 28, 6'd0, -1, 1'b0);
        drain("post_rst");

        // randomized traffic with random backpressure
        rdy_mode = 1'b1;
        for (int f = 0; f < 30; f++) begin
            r0 = $urandom; r1 = $urandom;
            case ($urandom_range(0, 3))
                0, 1:    dst = cfg_mac_addr;
                2:       dst = 48'hFFFF_FFFF_FFFF;
                default: dst = {r0[15:0], r1};
            endcase
            eth = ($urandom_range(0, 4) == 0) ? 16'($urandom) : cfg_ethertype;
            cfg_promisc = ($urandom_range(0, 3) == 0);
            send_frame(dst, eth, $urandom_range(1, 40),
                       ($urandom_range(0, 4) == 0) ? 6'($urandom_range(1, 63)) : 6'd0,
                       -1, 1'b1);
            drain($sformatf("rand%0d", f));
        end
        cfg_promisc = 1'b0;

        // push the accepted counter into saturation
        rdy_mode = 1'b0;
        for (int f = 0; f < SAT + 1; f++)
            send_frame(cfg_mac_addr, 16'h88B5, 4, 6'd0, -1, 1'b0);
        drain("saturate");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mpu_rx_frame_parser.md
Name: mpu_rx_frame_parser

Overview:
- Sits between the TSE MAC receive FIFO interface (Avalon-ST, 32-bit, RX_SHIFT16 enabled) and the MPU command/data ingress inside mpu_ss.
- Filters frames by destination MAC and EtherType, strips the 14-byte Ethernet header plus the 2-byte shift16 pad, and forwards the word-aligned payload as an Avalon-ST packet.
- Propagates MAC receive errors to the payload's eop beat and keeps saturating frame statistics.

Parameters:
- STAT_W, 16, width of each statistics counter.
- DEF_ETHERTYPE, 16'h88B5, EtherType accepted after reset (reset value of the internal cfg register shadow).

Ports:
- clk  in  1  single system clock (125 MHz domain)
- reset_n  in  1  asynchronous active-low reset
- rx_data  in  32  MAC ff_rx_data; byte 0 in bits [31:24]
- rx_valid  in  1  MAC ff_rx_dval
- rx_sop  in  1  MAC ff_rx_sop
- rx_eop  in  1  MAC ff_rx_eop
- rx_empty  in  2  MAC ff_rx_mod; valid only on the eop beat
- rx_err  in  6  MAC rx_err; valid only on the eop beat
- rx_ready  out  1  MAC ff_rx_rdy
- cfg_mac_addr  in  48  station address
- cfg_ethertype  in  16  accepted EtherType
- cfg_promisc  in  1  1 = accept any destination MAC
- out_data  out  32  payload word
- out_valid  out  1  payload beat valid
- out_ready  in  1  downstream ready
- out_sop  out  1  first payload beat
- out_eop  out  1  last payload beat
- out_empty  out  2  unused bytes on the eop beat
- out_err  out  1  frame error; meaningful on the eop beat
- stat_accepted  out  STAT_W  frames forwarded without error
- stat_filtered  out  STAT_W  frames dropped by the address/type filter or as runts
- stat_errored  out  STAT_W  forwarded frames closed with out_err

Behaviour:
Reset values
- All out_* = 0; rx_ready = 1; counters = 0; state = IDLE.

Header layout
- word0 = {pad16, dst[47:32]}
- word1 = dst[31:0]
- word2 = src[47:16]
- word3 = {src[15:0], ethertype}
- Payload starts at word4.

Beat acceptance
- A beat transfers when rx_valid & rx_ready.

States
- IDLE: rx_ready = 1.
  - Beats without sop are discarded.
  - An sop beat latches dst_hi and goes to HDR1.
- HDR1: latch dst_lo, go to HDR2.
- HDR2: ignore (source MAC), go to HDR3.
- HDR3: evaluate the filter from the latched values and this beat's [15:0].
  - match = (dst==cfg_mac_addr | dst==48'hFFFF_FFFF_FFFF | cfg_promisc) & ethertype==cfg_ethertype.
  - match → PAYLOAD with first_pending = 1.
  - No match → DROP; stat_filtered +1.
- PAYLOAD: rx_ready = ~out_valid | out_ready.
  - Each accepted beat loads the output register on the next edge: out_sop = first_pending, out_eop = rx_eop, out_empty = rx_eop ? rx_empty : 0, out_err = rx_eop & (|rx_err).
  - On eop: increment stat_errored if out_err, else stat_accepted; go to IDLE.
- DROP: rx_ready = 1; discard beats until eop, then go to IDLE.

Runts
- eop seen in HDR1–HDR3, or eop together with sop → stat_filtered +1, go to IDLE, nothing emitted.

Latency and handshake
- Latency is one clk from the accepted rx beat to out_valid.
- out_* hold stable while out_valid & ~out_ready.
- out_valid clears after a transfer unless a new beat loads in the same cycle. This sustains full throughput.

Sop during PAYLOAD (missing eop)
- rx_ready is forced low for that beat.
- Once the output register is free, emit an abort beat: out_data = 0, out_eop = 1, out_err = 1, out_empty = 0, out_sop = 0. stat_errored +1.
- Then go to IDLE with rx_ready = 1, so the same sop beat is accepted as a new header.

Sop during HDR1–HDR3 or DROP
- Restart the header at HDR1 with that beat. stat_filtered +1 for the abandoned frame.

Configuration sampling
- cfg_* are sampled in the HDR3 cycle only.
- Changes mid-frame do not affect the frame in progress.

Counters
- Saturate at all-ones, no wrap.
- At most one counter increments per cycle.

Reset mid-frame
- Asynchronous clear to reset values; any partial output packet is abandoned.
- Post-reset beats are dropped until the next sop.

Decomposition:
- Shared package mpu_eth_pkg:
  - state enum (IDLE, HDR1, HDR2, HDR3, PAYLOAD, DROP)
  - header word offsets
  - BROADCAST_MAC constant
  - DEF_ETHERTYPE constant
- One sub-module: mpu_sat_counter (parameter W; inc input, saturating), instantiated three times.

Test Plan:
- Matching unicast frame, 64 B payload, out_ready = 1 → 16 out beats; sop on beat 1; eop with out_empty = 0; stat_accepted = 1; first out_valid exactly 1 clk after word4 accepted.
- Frame with dst = 02:00:00:00:00:99 ≠ cfg and promisc = 0 → no out_valid; stat_filtered = 1. Repeat with cfg_promisc = 1 → forwarded.
- Broadcast frame, EtherType 0x0800 while cfg = 0x88B5 → dropped. Same frame with 0x88B5 → forwarded; 47-byte payload gives out_empty = 1 on eop.
- Matching frame with rx_err = 6'b000010 on eop → out_eop & out_err = 1; stat_errored = 1; stat_accepted unchanged.
- out_ready toggled 1/0 randomly over a 256-byte payload → payload byte-exact and in order; outputs stable while stalled; no beat lost or duplicated.
- sop arrives at payload word 6 with no eop → abort beat (data 0, eop = 1, err = 1); then the new frame is parsed and forwarded correctly. Separately, reset_n pulsed mid-payload → outputs clear, trailing beats ignored, next frame forwarded.
